// File: rtl/laser_if.sv
// Point-input and result bus of the laser-placement accelerator.
// Signal names follow the block's external pin names.
interface laser_if;
  logic [3:0] X;
  logic [3:0] Y;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;
  logic       DONE;

  modport master (output X, Y, input C1X, C1Y, C2X, C2Y, DONE);
  modport slave  (input X, Y, output C1X, C1Y, C2X, C2Y, DONE);
endinterface

// File: rtl/laser.sv
// Laser-placement accelerator: captures a point set, then alternately optimises two radius-4
// circle centres by raster scan until a pass brings no improvement.
module laser #(
  parameter int unsigned NPTS    = 40,
  parameter int unsigned R2      = 16,
  parameter int unsigned MAXPASS = 16
) (
  input logic    CLK,
  input logic    RST,
  laser_if.slave bus
);

  typedef enum logic [1:0] {StInput, StSearch, StDone} state_e;

  localparam logic [3:0] LastPass = 4'(MAXPASS - 1);

  state_e     state_q, state_d;
  logic [7:0] pts_q [NPTS];
  logic [7:0] pts_d [NPTS];
  logic [5:0] idx_q, idx_d;
  logic [3:0] pass_q, pass_d;
  logic [7:0] cand_q, cand_d;
  logic       start_q, start_d;
  logic       improved_q, improved_d;
  logic [5:0] best_q, best_d;
  logic [7:0] c1_q, c1_d;   // {y, x}
  logic [7:0] c2_q, c2_d;   // {y, x}

  logic            c1_pass;
  logic [7:0]      cur, other, probe;
  logic [NPTS-1:0] cov_union;
  logic [5:0]      cnt;
  logic            better;

  function automatic logic covers(input logic [7:0] c, input logic [7:0] p);
    logic [3:0] dx, dy;
    logic [5:0] ss;
    dx = (c[3:0] >= p[3:0]) ? c[3:0] - p[3:0] : p[3:0] - c[3:0];
    dy = (c[7:4] >= p[7:4]) ? c[7:4] - p[7:4] : p[7:4] - c[7:4];
    ss = {3'b000, dx[2:0]} * {3'b000, dx[2:0]} + {3'b000, dy[2:0]} * {3'b000, dy[2:0]};
    return (dx <= 4'd4) && (dy <= 4'd4) && (ss <= 6'(R2));
  endfunction

  // The pass-start cycle probes the centre under optimisation itself, so cnt yields the
  // current union count that seeds best for passes after the first.
  always_comb begin
    c1_pass = ~pass_q[0];
    cur     = c1_pass ? c1_q : c2_q;
    other   = c1_pass ? c2_q : c1_q;
    probe   = start_q ? cur : cand_q;
    cnt     = '0;
    for (int i = 0; i < NPTS; i++) begin
      cov_union[i] = covers(probe, pts_q[i]) || ((pass_q != 4'd0) && covers(other, pts_q[i]));
      cnt          = cnt + 6'(cov_union[i]);
    end
    better = cnt > best_q;
  end

  always_comb begin
    state_d    = state_q;
    pts_d      = pts_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    cand_d     = cand_q;
    start_d    = start_q;
    improved_d = improved_q;
    best_d     = best_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    unique case (state_q)
      StInput: begin
        for (int i = 0; i < NPTS; i++) begin
          if (idx_q == 6'(i)) pts_d[i] = {bus.Y, bus.X};
        end
        if (idx_q == 6'(NPTS - 1)) begin
          idx_d      = '0;
          state_d    = StSearch;
          start_d    = 1'b1;
          pass_d     = '0;
          cand_d     = '0;
          c1_d       = '0;
          c2_d       = '0;
          best_d     = '0;
          improved_d = 1'b0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StSearch: begin
        if (start_q) begin
          start_d    = 1'b0;
          best_d     = (pass_q == 4'd0) ? 6'd0 : cnt;
          improved_d = 1'b0;
          cand_d     = '0;
        end else begin
          if (better) begin
            best_d     = cnt;
            improved_d = 1'b1;
            if (c1_pass) c1_d = cand_q;
            else         c2_d = cand_q;
          end
          cand_d = cand_q + 8'd1;
          if (cand_q == 8'hFF) begin
            if (((pass_q != 4'd0) && !(improved_q || better)) || (pass_q == LastPass)) begin
              state_d = StDone;
            end else begin
              pass_d  = pass_q + 4'd1;
              start_d = 1'b1;
            end
          end
        end
      end
      StDone: begin
        state_d = StInput;
        idx_d   = '0;
      end
      default: state_d = StInput;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StInput;
      for (int i = 0; i < NPTS; i++) pts_q[i] <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      cand_q     <= '0;
      start_q    <= 1'b0;
      improved_q <= 1'b0;
      best_q     <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
    end else begin
      state_q    <= state_d;
      pts_q      <= pts_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      cand_q     <= cand_d;
      start_q    <= start_d;
      improved_q <= improved_d;
      best_q     <= best_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
    end
  end

  assign bus.C1X  = c1_q[3:0];
  assign bus.C1Y  = c1_q[7:4];
  assign bus.C2X  = c2_q[3:0];
  assign bus.C2Y  = c2_q[7:4];
  assign bus.DONE = (state_q == StDone);

endmodule

// File: tb/tb_laser.sv
// Directed and randomised checks of the laser-placement accelerator against a
// software model of the alternating-pass centre search.
module tb_laser;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] pts [40];   // {y, x}

  always #5 clk = ~clk;

  laser_if bus ();

  laser dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  function automatic bit cov(input int cx, input int cy, input logic [7:0] p);
    int dx, dy;
    dx = cx - int'(p[3:0]);
    dy = cy - int'(p[7:4]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx * dx + dy * dy) <= 16;
  endfunction

  function automatic int ucount(input int ax, input int ay, input int bx, input int by,
                                input bit use_b);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (cov(ax, ay, pts[i]) || (use_b && cov(bx, by, pts[i]))) n++;
    end
    return n;
  endfunction

  task automatic run_model(output int r1x, output int r1y, output int r2x, output int r2y,
                           output int rbest);
    int c1x, c1y, c2x, c2y, best, n;
    bit imp;
    c1x = 0; c1y = 0; c2x = 0; c2y = 0; best = 0;
    for (int p = 1; p <= 16; p++) begin
      best = (p == 1) ? 0 : ucount(c1x, c1y, c2x, c2y, 1'b1);
      imp  = 1'b0;
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 16; x++) begin
          if (p % 2 == 1) n = ucount(x, y, c2x, c2y, p > 1);
          else            n = ucount(c1x, c1y, x, y, 1'b1);
          if (n > best) begin
            best = n;
            imp  = 1'b1;
            if (p % 2 == 1) begin c1x = x; c1y = y; end
            else            begin c2x = x; c2y = y; end
          end
        end
      end
      if (p >= 2 && !imp) break;
    end
    r1x = c1x; r1y = c1y; r2x = c2x; r2y = c2y; rbest = best;
  endtask

  // Drives one set; the edge after each assignment captures that point.
  task automatic feed();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rst   = 1'b1;
      bus.X = pts[i][3:0];
      bus.Y = pts[i][7:4];
      total++;
      if (bus.DONE !== 1'b0) begin
        bad++;
        $display("FAIL done_during_input idx=%0d got=%b want=0", i, bus.DONE);
      end
    end
    @(posedge clk);
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 5000) begin
      @(negedge clk);
      lat++;
      if (bus.DONE === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.X = '0;
    bus.Y = '0;
    rst   = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (bus.DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.DONE); end
    if (bus.C1X !== 4'd0) begin bad++; $display("FAIL reset_c1x got=%0d want=0", bus.C1X); end
    if (bus.C1Y !== 4'd0) begin bad++; $display("FAIL reset_c1y got=%0d want=0", bus.C1Y); end
    if (bus.C2X !== 4'd0) begin bad++; $display("FAIL reset_c2x got=%0d want=0", bus.C2X); end
    if (bus.C2Y !== 4'd0) begin bad++; $display("FAIL reset_c2y got=%0d want=0", bus.C2Y); end
  endtask

  task automatic test_same_points();
    int  lat;
    bit  ok;
    for (int i = 0; i < 40; i++) pts[i] = 8'h88;
    feed();
    wait_done(lat, ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL same_done_timeout got=none want=DONE"); end
    if ({bus.C1X, bus.C1Y} !== {4'd8, 4'd4}) begin
      bad++; $display("FAIL same_c1 got=(%0d,%0d) want=(8,4)", bus.C1X, bus.C1Y);
    end
    if ({bus.C2X, bus.C2Y} !== {4'd0, 4'd0}) begin
      bad++; $display("FAIL same_c2 got=(%0d,%0d) want=(0,0)", bus.C2X, bus.C2Y);
    end
    if (ucount(bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 1'b1) != 40) begin
      bad++; $display("FAIL same_cover got=%0d want=40",
                      ucount(bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 1'b1));
    end
  endtask

  // Runs straight after a DONE with no reset in between.
  task automatic test_back_to_back();
    int lat;
    bit ok;
    for (int i = 0; i < 40; i++) pts[i] = 8'hFF;
    feed();
    wait_done(lat, ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL b2b_done_timeout got=none want=DONE"); end
    if ({bus.C1X, bus.C1Y} !== {4'd15, 4'd11}) begin
      bad++; $display("FAIL b2b_c1 got=(%0d,%0d) want=(15,11)", bus.C1X, bus.C1Y);
    end
    if ({bus.C2X, bus.C2Y} !== {4'd0, 4'd0}) begin
      bad++; $display("FAIL b2b_c2 got=(%0d,%0d) want=(0,0)", bus.C2X, bus.C2Y);
    end
  endtask

  task automatic test_two_clusters();
    int lat;
    bit ok;
    pulse_reset();
    for (int i = 0; i < 40; i++) pts[i] = (i % 2 == 0) ? 8'h22 : 8'hDD;
    feed();
    wait_done(lat, ok);
    total += 5;
    if (!ok) begin bad++; $display("FAIL clus_done_timeout got=none want=DONE"); end
    if ({bus.C1X, bus.C1Y} !== {4'd0, 4'd0}) begin
      bad++; $display("FAIL clus_c1 got=(%0d,%0d) want=(0,0)", bus.C1X, bus.C1Y);
    end
    if ({bus.C2X, bus.C2Y} !== {4'd13, 4'd9}) begin
      bad++; $display("FAIL clus_c2 got=(%0d,%0d) want=(13,9)", bus.C2X, bus.C2Y);
    end
    if (ucount(bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 1'b1) != 40) begin
      bad++; $display("FAIL clus_cover got=%0d want=40",
                      ucount(bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 1'b1));
    end
    @(negedge clk);
    if (bus.DONE !== 1'b0) begin bad++; $display("FAIL clus_done_width got=%b want=0", bus.DONE); end
  endtask

  task automatic test_mid_reset();
    int lat, m1x, m1y, m2x, m2y, mb;
    bit ok;
    pulse_reset();
    for (int i = 0; i < 40; i++) pts[i] = 8'($urandom_range(0, 255));
    feed();
    repeat (100) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.DONE !== 1'b0) begin bad++; $display("FAIL midrst_done cyc=%0d got=%b want=0", k, bus.DONE); end
    end
    total++;
    if ({bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} !== 16'h0000) begin
      bad++; $display("FAIL midrst_outputs got=%h want=0000", {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y});
    end
    for (int i = 0; i < 40; i++) pts[i] = 8'($urandom_range(0, 255));
    run_model(m1x, m1y, m2x, m2y, mb);
    feed();
    wait_done(lat, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL midrst_after_timeout got=none want=DONE"); end
    if ({bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} !== {4'(m1x), 4'(m1y), 4'(m2x), 4'(m2y)}) begin
      bad++; $display("FAIL midrst_after_centres got=(%0d,%0d)(%0d,%0d) want=(%0d,%0d)(%0d,%0d)",
                      bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, m1x, m1y, m2x, m2y);
    end
  endtask

  task automatic test_random();
    int lat, m1x, m1y, m2x, m2y, mb, got;
    bit ok;
    pulse_reset();
    for (int s = 0; s < 50; s++) begin
      for (int i = 0; i < 40; i++) pts[i] = 8'($urandom_range(0, 255));
      run_model(m1x, m1y, m2x, m2y, mb);
      feed();
      wait_done(lat, ok);
      total += 3;
      if (!ok) begin
        bad++; $display("FAIL rand_latency set=%0d got>=%0d want<5000", s, lat);
      end
      if ({bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} !== {4'(m1x), 4'(m1y), 4'(m2x), 4'(m2y)}) begin
        bad++; $display("FAIL rand_centres set=%0d got=(%0d,%0d)(%0d,%0d) want=(%0d,%0d)(%0d,%0d)",
                        s, bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, m1x, m1y, m2x, m2y);
      end
      got = ucount(bus.C1X, bus.C1Y, bus.C2X, bus.C2Y, 1'b1);
      if (got != mb) begin
        bad++; $display("FAIL rand_cover set=%0d got=%0d want=%0d", s, got, mb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_points();
    test_back_to_back();
    test_two_clusters();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
